// File: rtl/mux_arb_4to1_if.sv
// ---------------------------------------------------------------------------
// mux_arb_4to1_if
//   Bundle of the requester and downstream signals of the 4:1 packet arbiter.
//
//   Handshake: a beat moves across a channel only in a cycle where that
//   channel's valid and ready are both high at the rising clock edge.
//   Valid never waits on ready. Ready may be high without valid.
//
//   Signals
//     in_valid[3:0]   requester valid (bit 0 = a, 1 = b, 2 = c, 3 = d)
//     in_last[3:0]    final beat of the requester's packet
//     in_a..in_d      requester data, WIDTH bits each
//     in_ready[3:0]   per-requester ready, at most one bit high
//     out_valid       output register holds a beat
//     out_ready       downstream ready
//     out_data        registered selected data
//     out_src         requester index of the beat in out_data
//     out_last        registered in_last of the selected requester
//     sel             combinational mux select (current winner)
//
//   Modports
//     master : the requester/downstream side (drives in_*, out_ready)
//     slave  : the arbiter
// ---------------------------------------------------------------------------
interface mux_arb_4to1_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       in_valid;
  logic [3:0]       in_last;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic [WIDTH-1:0] in_d;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
  logic             out_last;
  logic [1:0]       sel;

  modport master (
    output in_valid,
    output in_last,
    output in_a,
    output in_b,
    output in_c,
    output in_d,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_src,
    input  out_last,
    input  sel
  );

  modport slave (
    input  in_valid,
    input  in_last,
    input  in_a,
    input  in_b,
    input  in_c,
    input  in_d,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_src,
    output out_last,
    output sel
  );
endinterface

// File: rtl/mux_arb_4to1.sv
// ---------------------------------------------------------------------------
// mux_arb_4to1
//   Four-requester packet arbiter feeding a single-entry output register.
//   Arbitration is round-robin between packets; once a multi-beat packet
//   starts, the grant is locked to that requester until its last beat.
//
//   Ports
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     bus          mux_arb_4to1_if.slave (requester inputs, output stage)
//     dbg_state_o  FSM state (0 = ARB, 1 = LOCK)
//     dbg_ptr_o    round-robin pointer (last granted requester in ARB)
// ---------------------------------------------------------------------------
module mux_arb_4to1 #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_arb_4to1_if.slave bus,
  output logic         dbg_state_o,
  output logic [1:0]   dbg_ptr_o
);

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_src_q, out_src_d;
  logic             out_last_q, out_last_d;

  logic             rr_found;
  logic [1:0]       rr_idx;
  logic [1:0]       cand;
  logic             win_valid;
  logic [1:0]       win_idx;
  logic [WIDTH-1:0] win_data;
  logic             win_last;
  logic             can_load;
  logic             xfer;
  logic [3:0]       in_ready_c;

  // Round-robin search starting one past the pointer, wrapping 3 -> 0.
  // Reset leaves ptr at 3 so the first search begins at requester 0.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    cand     = ptr_q;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!rr_found && bus.in_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // In LOCK the winner is the locked requester, held in sel_q, whether or
  // not it is currently valid; a missing valid simply stalls the packet.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = sel_q;
    if (state_q == ST_LOCK) begin
      win_valid = 1'b1;
      win_idx   = sel_q;
    end else if (rr_found) begin
      win_valid = 1'b1;
      win_idx   = rr_idx;
    end
  end

  always_comb begin
    win_data = bus.in_a;
    unique case (win_idx)
      2'd0: win_data = bus.in_a;
      2'd1: win_data = bus.in_b;
      2'd2: win_data = bus.in_c;
      2'd3: win_data = bus.in_d;
      default: win_data = bus.in_a;
    endcase
  end

  assign win_last = bus.in_last[win_idx];
  assign can_load = !out_valid_q || bus.out_ready;
  assign xfer     = win_valid && can_load && bus.in_valid[win_idx];

  // With no request in ARB the select keeps its previous value.
  assign sel_d = win_valid ? win_idx : sel_q;

  // Combinational outputs are forced to zero while reset is asserted so
  // the whole interface is quiet during reset, not just the registers.
  always_comb begin
    in_ready_c = 4'b0000;
    if (rst_n && win_valid) begin
      in_ready_c[win_idx] = can_load;
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.sel      = rst_n ? sel_d : 2'd0;

  // FSM and round-robin pointer. The pointer only moves on grants made in
  // ARB, so the next packet search starts after the requester that just
  // finished a packet.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      if (state_q == ST_ARB) begin
        ptr_d = win_idx;
        if (!win_last) begin
          state_d = ST_LOCK;
        end
      end else if (win_last) begin
        state_d = ST_ARB;
      end
    end
  end

  // Output register: load on an input transfer (which also covers the
  // drain-and-refill case), otherwise empty it when the beat is taken.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = win_data;
      out_src_d   = win_idx;
      out_last_d  = win_last;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ARB;
      ptr_q       <= 2'd3;
      sel_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_last  = out_last_q;

  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

endmodule
